// File: rtl/adam_periph_spi_buf.sv
// Stream buffer between the SPI register interface and the SPI phy.
// A TX FIFO feeds the phy, an RX FIFO collects phy frames for software.
// Both FIFOs report occupancy, support flush and freeze while paused.

module adam_periph_spi_buf_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign in_ready  = !rst && (count != FULL) && !hold && !flush;
  assign out_valid = !rst && (count != '0) && !hold;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy tracking; flush overrides any pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; data is never reset, occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

module adam_periph_spi_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pause_req,
  output logic                       pause_ack,
  input  logic                       tx_flush,
  input  logic                       rx_flush,
  input  logic                       overrun_clr,
  input  logic [DATA_WIDTH-1:0]      reg_tx_data,
  input  logic                       reg_tx_valid,
  output logic                       reg_tx_ready,
  output logic [DATA_WIDTH-1:0]      phy_tx_data,
  output logic                       phy_tx_valid,
  input  logic                       phy_tx_ready,
  input  logic [DATA_WIDTH-1:0]      phy_rx_data,
  input  logic                       phy_rx_valid,
  output logic                       phy_rx_ready,
  output logic [DATA_WIDTH-1:0]      reg_rx_data,
  output logic                       reg_rx_valid,
  input  logic                       reg_rx_ready,
  output logic [$clog2(TX_DEPTH):0]  tx_count,
  output logic [$clog2(RX_DEPTH):0]  rx_count,
  output logic                       tx_empty,
  output logic                       rx_full,
  output logic                       rx_overrun
);

  localparam int                 RAW     = $clog2(RX_DEPTH);
  localparam logic [RAW:0]       RX_FULL = (RAW+1)'(RX_DEPTH);

  typedef enum logic {RUN, PAUSED} pause_state_t;

  pause_state_t state_q;
  pause_state_t state_d;
  logic         paused;

  // Streams freeze as soon as a pause is requested and stay frozen until ack drops.
  assign paused   = pause_req || pause_ack;
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == RX_FULL);

  // Pause state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Pause next-state and acknowledge decode.
  always_comb begin
    state_d   = state_q;
    pause_ack = 1'b0;
    case (state_q)
      RUN:    if (pause_req)  state_d = PAUSED;
      PAUSED: begin
        pause_ack = 1'b1;
        if (!pause_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Sticky overrun: a stalled phy frame wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rx_overrun <= 1'b0;
    else if (phy_rx_valid && rx_full) rx_overrun <= 1'b1;
    else if (overrun_clr)            rx_overrun <= 1'b0;
  end

  adam_periph_spi_buf_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .hold      (paused),
    .flush     (tx_flush),
    .in_data   (reg_tx_data),
    .in_valid  (reg_tx_valid),
    .in_ready  (reg_tx_ready),
    .out_data  (phy_tx_data),
    .out_valid (phy_tx_valid),
    .out_ready (phy_tx_ready),
    .count     (tx_count)
  );

  adam_periph_spi_buf_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .hold      (paused),
    .flush     (rx_flush),
    .in_data   (phy_rx_data),
    .in_valid  (phy_rx_valid),
    .in_ready  (phy_rx_ready),
    .out_data  (reg_rx_data),
    .out_valid (reg_rx_valid),
    .out_ready (reg_rx_ready),
    .count     (rx_count)
  );

endmodule

// File: tb/tb_adam_periph_spi_buf.sv
// Directed self-checking bench for adam_periph_spi_buf.
module tb_adam_periph_spi_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        pause_req, pause_ack;
  logic        tx_flush, rx_flush, overrun_clr;
  logic [31:0] reg_tx_data;  logic reg_tx_valid, reg_tx_ready;
  logic [31:0] phy_tx_data;  logic phy_tx_valid, phy_tx_ready;
  logic [31:0] phy_rx_data;  logic phy_rx_valid, phy_rx_ready;
  logic [31:0] reg_rx_data;  logic reg_rx_valid, reg_rx_ready;
  logic [3:0]  tx_count, rx_count;
  logic        tx_empty, rx_full, rx_overrun;

  int total = 0;
  int bad   = 0;

  adam_periph_spi_buf #(.DATA_WIDTH(32), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .pause_req(pause_req), .pause_ack(pause_ack),
    .tx_flush(tx_flush), .rx_flush(rx_flush), .overrun_clr(overrun_clr),
    .reg_tx_data(reg_tx_data), .reg_tx_valid(reg_tx_valid), .reg_tx_ready(reg_tx_ready),
    .phy_tx_data(phy_tx_data), .phy_tx_valid(phy_tx_valid), .phy_tx_ready(phy_tx_ready),
    .phy_rx_data(phy_rx_data), .phy_rx_valid(phy_rx_valid), .phy_rx_ready(phy_rx_ready),
    .reg_rx_data(reg_rx_data), .reg_rx_valid(reg_rx_valid), .reg_rx_ready(reg_rx_ready),
    .tx_count(tx_count), .rx_count(rx_count), .tx_empty(tx_empty), .rx_full(rx_full),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pause_req = 0; tx_flush = 0; rx_flush = 0; overrun_clr = 0;
    reg_tx_data = 0; reg_tx_valid = 0; phy_tx_ready = 0;
    phy_rx_data = 0; phy_rx_valid = 0; reg_rx_ready = 0;
    #2;
    // Reset state
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_rx_count", 32'(rx_count), 0);
    chk("rst_tx_empty", 32'(tx_empty), 1);
    chk("rst_rx_full", 32'(rx_full), 0);
    chk("rst_overrun", 32'(rx_overrun), 0);
    chk("rst_ack", 32'(pause_ack), 0);
    chk("rst_reg_tx_ready", 32'(reg_tx_ready), 0);
    chk("rst_phy_rx_ready", 32'(phy_rx_ready), 0);
    tick(); tick();
    rst = 1'b0;
    #1;

    // Fill TX with 0xAA..0xB1 while phy stalls
    for (int i = 0; i < 8; i++) begin
      reg_tx_data = 32'hAA + 32'(i); reg_tx_valid = 1;
      #1 chk("fill_ready", 32'(reg_tx_ready), 1);
      tick();
    end
    reg_tx_data = 32'hB2;
    #1;
    chk("fill_count", 32'(tx_count), 8);
    chk("fill_9th_ready", 32'(reg_tx_ready), 0);
    chk("fill_head", phy_tx_data, 32'hAA);
    tick();
    reg_tx_valid = 0;
    chk("fill_count_hold", 32'(tx_count), 8);
    phy_tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("drain_valid", 32'(phy_tx_valid), 1);
      chk("drain_data", phy_tx_data, 32'hAA + 32'(i));
      tick();
    end
    chk("drain_empty", 32'(tx_empty), 1);
    chk("drain_valid_low", 32'(phy_tx_valid), 0);
    phy_tx_ready = 0;

    // Concurrent push/pop at depth 4
    for (int i = 0; i < 4; i++) begin
      reg_tx_data = 32'h100 + 32'(i); reg_tx_valid = 1; tick();
    end
    phy_tx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      reg_tx_data = 32'h104 + 32'(i); reg_tx_valid = 1;
      #1;
      chk("conc_data", phy_tx_data, 32'h100 + 32'(i));
      tick();
      chk("conc_count", 32'(tx_count), 4);
    end
    reg_tx_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("conc_tail", phy_tx_data, 32'h114 + 32'(i));
      tick();
    end
    chk("conc_empty", 32'(tx_empty), 1);
    phy_tx_ready = 0;

    // RX overrun
    for (int i = 0; i < 9; i++) begin
      phy_rx_data = 32'h10 + 32'(i); phy_rx_valid = 1; tick();
    end
    chk("ovr_count", 32'(rx_count), 8);
    chk("ovr_full", 32'(rx_full), 1);
    chk("ovr_ready", 32'(phy_rx_ready), 0);
    chk("ovr_flag", 32'(rx_overrun), 1);
    overrun_clr = 1; tick();
    chk("ovr_set_wins", 32'(rx_overrun), 1);
    phy_rx_valid = 0; tick();
    overrun_clr = 0;
    chk("ovr_cleared", 32'(rx_overrun), 0);
    reg_rx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rx_drain_valid", 32'(reg_rx_valid), 1);
      chk("rx_drain_data", reg_rx_data, 32'h10 + 32'(i));
      tick();
    end
    chk("rx_drain_count", 32'(rx_count), 0);
    reg_rx_ready = 0;

    // TX flush coincident with a push
    for (int i = 0; i < 5; i++) begin
      reg_tx_data = 32'h50 + 32'(i); reg_tx_valid = 1; tick();
    end
    chk("fl_count_pre", 32'(tx_count), 5);
    reg_tx_data = 32'h55; tx_flush = 1;
    #1 chk("fl_ready", 32'(reg_tx_ready), 0);
    tick();
    tx_flush = 0; reg_tx_valid = 0;
    chk("fl_count", 32'(tx_count), 0);
    chk("fl_valid", 32'(phy_tx_valid), 0);
    reg_tx_data = 32'h60; reg_tx_valid = 1; tick();
    reg_tx_valid = 0;
    chk("fl_new_head", phy_tx_data, 32'h60);
    phy_tx_ready = 1; tick(); phy_tx_ready = 0;
    chk("fl_new_empty", 32'(tx_empty), 1);

    // RX flush
    phy_rx_data = 32'h33; phy_rx_valid = 1; tick(); tick();
    phy_rx_valid = 0;
    chk("rxfl_pre", 32'(rx_count), 2);
    rx_flush = 1; tick(); rx_flush = 0;
    chk("rxfl_count", 32'(rx_count), 0);

    // Pause with 3 words queued
    for (int i = 0; i < 3; i++) begin
      reg_tx_data = 32'h70 + 32'(i); reg_tx_valid = 1; tick();
    end
    reg_tx_valid = 0;
    pause_req = 1;
    #1;
    chk("pz_ack_early", 32'(pause_ack), 0);
    chk("pz_valid_req", 32'(phy_tx_valid), 0);
    tick();
    phy_tx_ready = 1;
    chk("pz_ack", 32'(pause_ack), 1);
    chk("pz_reg_tx_ready", 32'(reg_tx_ready), 0);
    chk("pz_phy_rx_ready", 32'(phy_rx_ready), 0);
    chk("pz_reg_rx_valid", 32'(reg_rx_valid), 0);
    tick();
    chk("pz_count", 32'(tx_count), 3);
    pause_req = 0;
    #1 chk("pz_valid_ack", 32'(phy_tx_valid), 0);
    tick();
    chk("pz_ack_low", 32'(pause_ack), 0);
    chk("pz_count_kept", 32'(tx_count), 3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pz_drain_valid", 32'(phy_tx_valid), 1);
      chk("pz_drain_data", phy_tx_data, 32'h70 + 32'(i));
      tick();
    end
    chk("pz_empty", 32'(tx_empty), 1);
    phy_tx_ready = 0;

    // Reset mid-operation with 6 words in each FIFO
    for (int i = 0; i < 6; i++) begin
      reg_tx_data = 32'h80 + 32'(i); reg_tx_valid = 1;
      phy_rx_data = 32'h90 + 32'(i); phy_rx_valid = 1;
      tick();
    end
    reg_tx_valid = 0; phy_rx_valid = 0;
    chk("mid_tx_count", 32'(tx_count), 6);
    chk("mid_rx_count", 32'(rx_count), 6);
    #2 rst = 1;
    #1;
    chk("mid_tx_valid", 32'(phy_tx_valid), 0);
    chk("mid_rx_valid", 32'(reg_rx_valid), 0);
    chk("mid_tx_count_rst", 32'(tx_count), 0);
    chk("mid_rx_count_rst", 32'(rx_count), 0);
    chk("mid_overrun", 32'(rx_overrun), 0);
    chk("mid_ack", 32'(pause_ack), 0);
    tick();
    rst = 0;
    tick();
    chk("post_empty", 32'(tx_empty), 1);
    chk("post_ready", 32'(reg_tx_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
